// File: rtl/yari_mem_pkg.sv
// Shared memory-subsystem definitions: transaction ids, bus widths and the
// arbiter owner encoding used by mem_arbiter and its helpers.
package yari_mem_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  localparam logic [1:0] ID_DC = 2'd1;
  localparam logic [1:0] ID_IC = 2'd2;
  localparam logic [1:0] ID_FB = 2'd3;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_FB   = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arb_stats.sv
// Free-running wrap-around counters of CPU stall cycles and accepted
// frame-buffer transfers; only built when MEM_ARB_STATS_EN is defined.
module mem_arb_stats (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_stall_i,
  input  logic        fb_grant_i,
  output logic [31:0] stat_cpu_stall_o,
  output logic [31:0] stat_fb_grants_o
);

  logic [31:0] cpu_stall_q, cpu_stall_d;
  logic [31:0] fb_grants_q, fb_grants_d;

  always_comb begin
    cpu_stall_d = cpu_stall_q + {31'd0, cpu_stall_i};
    fb_grants_d = fb_grants_q + {31'd0, fb_grant_i};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cpu_stall_q <= '0;
      fb_grants_q <= '0;
    end else begin
      cpu_stall_q <= cpu_stall_d;
      fb_grants_q <= fb_grants_d;
    end
  end

  assign stat_cpu_stall_o = cpu_stall_q;
  assign stat_fb_grants_o = fb_grants_q;

endmodule

// File: rtl/mem_arbiter.sv
// CPU / frame-buffer arbiter in front of ssram_ctrl with stall locking and a
// bounded FB priority run. Optional statistics under MEM_ARB_STATS_EN.
module mem_arbiter
  import yari_mem_pkg::*;
#(
  parameter int unsigned FB_MAX = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [1:0]        cpu_id,
  input  logic [DATA_W-1:0] cpu_writedata,
  input  logic [MASK_W-1:0] cpu_writedatamask,
  output logic              cpu_waitrequest,
  input  logic [ADDR_W-1:0] fb_address,
  input  logic              fb_read,
  output logic              fb_waitrequest,
  output logic [ADDR_W-1:0] mem_address,
  output logic [1:0]        mem_id,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic [MASK_W-1:0] mem_writedatamask,
`ifdef MEM_ARB_STATS_EN
  output logic [31:0]       stat_cpu_stall,
  output logic [31:0]       stat_fb_grants,
`endif
  input  logic              mem_waitrequest
);

  localparam logic [7:0] FB_MAX_W = 8'(FB_MAX);

  logic       cpu_req, fb_req, accept;
  owner_e     owner, lock_q, lock_d;
  logic [7:0] streak_q, streak_d;

  assign cpu_req = cpu_read | cpu_write;
  assign fb_req  = fb_read;

  // A locked master that drops its request yields NONE; the lock then clears.
  always_comb begin
    owner = OWN_NONE;
    if (!reset_n)
      owner = OWN_NONE;
    else if (lock_q == OWN_CPU)
      owner = cpu_req ? OWN_CPU : OWN_NONE;
    else if (lock_q == OWN_FB)
      owner = fb_req ? OWN_FB : OWN_NONE;
    else if (fb_req && (streak_q < FB_MAX_W || !cpu_req))
      owner = OWN_FB;
    else if (cpu_req)
      owner = OWN_CPU;
  end

  assign accept = (owner != OWN_NONE) && !mem_waitrequest;

  always_comb begin
    lock_d   = (owner != OWN_NONE && mem_waitrequest) ? owner : OWN_NONE;
    streak_d = streak_q;
    if (!cpu_req)
      streak_d = '0;
    else if (accept && owner == OWN_CPU)
      streak_d = '0;
    else if (accept && owner == OWN_FB && streak_q < FB_MAX_W)
      streak_d = streak_q + 8'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_q   <= OWN_NONE;
      streak_q <= '0;
    end else begin
      lock_q   <= lock_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    mem_address       = cpu_address;
    mem_id            = cpu_id;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_writedata     = cpu_writedata;
    mem_writedatamask = cpu_writedatamask;
    if (owner == OWN_CPU) begin
      mem_read  = cpu_read;
      mem_write = cpu_write;
    end else if (owner == OWN_FB) begin
      mem_address = fb_address;
      mem_id      = ID_FB;
      mem_read    = 1'b1;
    end
  end

  assign cpu_waitrequest = (owner != OWN_CPU) | mem_waitrequest;
  assign fb_waitrequest  = (owner != OWN_FB) | mem_waitrequest;

`ifdef MEM_ARB_STATS_EN
  mem_arb_stats u_stats (
    .clock            (clock),
    .reset_n          (reset_n),
    .cpu_stall_i      (cpu_req & cpu_waitrequest),
    .fb_grant_i       (accept && owner == OWN_FB),
    .stat_cpu_stall_o (stat_cpu_stall),
    .stat_fb_grants_o (stat_fb_grants)
  );
`endif

  a_cpu_lock_held: assert property (@(posedge clock) disable iff (!reset_n)
    (lock_q == OWN_CPU) |-> cpu_req);
  a_fb_lock_held: assert property (@(posedge clock) disable iff (!reset_n)
    (lock_q == OWN_FB) |-> fb_req);

endmodule
